// File: rtl/flag_update_sequencer_pkg.sv
// Shared types and decode helpers for the ZCSO flag update sequencer.
// Holds the op-code to update-mask decode and the per-condition flag needs.
package flag_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    localparam logic [3:0] MASK_Z = 4'b0001;
    localparam logic [3:0] MASK_C = 4'b0010;
    localparam logic [3:0] MASK_S = 4'b0100;
    localparam logic [3:0] MASK_O = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COMMIT
    } state_e;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_LT = 4'd9,
        COND_GE = 4'd10,
        COND_LE = 4'd11,
        COND_GT = 4'd12,
        COND_LS = 4'd13,
        COND_HI = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic logic [3:0] op_flag_mask(input logic [4:0] op_code);
        logic [3:0] mask;
        case (op_code) inside
            5'b01000, 5'b01001:                         mask = MASK_S | MASK_C | MASK_Z;
            5'b00000, 5'b00001, [5'b00011:5'b00110]:    mask = 4'b1111;
            5'b10001, 5'b10010, [5'b10100:5'b11110]:    mask = MASK_S | MASK_Z;
            default:                                    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [3:0] cond_flag_need(input logic [3:0] cond_code);
        logic [3:0] need;
        case (cond_code)
            COND_EQ, COND_NE: need = MASK_Z;
            COND_CS, COND_CC: need = MASK_C;
            COND_MI, COND_PL: need = MASK_S;
            COND_VS, COND_VC: need = MASK_O;
            COND_LT, COND_GE: need = MASK_S | MASK_O;
            COND_LE, COND_GT: need = MASK_Z | MASK_S | MASK_O;
            COND_LS, COND_HI: need = MASK_C | MASK_Z;
            default:          need = 4'b0000;
        endcase
        return need;
    endfunction

endpackage

// File: rtl/flag_update_sequencer_cond_eval.sv
// Combinational branch condition evaluator over a {O,S,C,Z} flag vector.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond_code,
    output logic       taken
);

    logic z, c, s, o;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign s = flags[FLAG_S];
    assign o = flags[FLAG_O];

    always_comb begin
        taken = 1'b0;
        case (cond_code)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = s;
            COND_PL: taken = !s;
            COND_VS: taken = o;
            COND_VC: taken = !o;
            COND_LT: taken = s ^ o;
            COND_GE: taken = !(s ^ o);
            COND_LE: taken = z | (s ^ o);
            COND_GT: taken = !z & !(s ^ o);
            COND_LS: taken = c | z;
            COND_HI: taken = !c & !z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_update_sequencer.sv
// Tracks issued ALU ops through their latency, strobes the flag register in COMMIT,
// and serves branch condition requests with hazard stalls and commit-cycle forwarding.
module flag_update_sequencer
    import flag_pkg::*;
#(
    parameter int ALU_LAT = 1
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [4:0] op_code,
    output logic       op_ready,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_s,
    input  logic       alu_o,
    input  logic [3:0] flags_q,
    output logic [3:0] flag_we,
    output logic [3:0] flag_d,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       cond_done,
    output logic       cond_taken,
    output logic       busy
);

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] samp_q, samp_d;
    logic       cond_done_q, cond_done_d;
    logic       cond_taken_q, cond_taken_d;

    logic [3:0] op_mask;
    logic       op_accept;
    logic [3:0] cond_need;
    logic [3:0] eval_flags;
    logic       eval_taken;
    logic       cond_accept;

    assign op_ready  = (state_q != ST_WAIT);
    assign busy      = (state_q != ST_IDLE);
    assign op_mask   = op_flag_mask(op_code);
    assign op_accept = op_valid && op_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        samp_d  = samp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_accept && (op_mask != 4'b0000)) begin
                    mask_d  = op_mask;
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    samp_d  = {alu_o, alu_s, alu_c, alu_z} & mask_q;
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_COMMIT: begin
                // A new op here chains straight into WAIT so back-to-back updates leave no gap.
                if (op_accept && (op_mask != 4'b0000)) begin
                    mask_d  = op_mask;
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flag_we = 4'b0000;
        flag_d  = 4'b0000;
        if (state_q == ST_COMMIT) begin
            flag_we = mask_q;
            flag_d  = samp_q;
        end
    end

    // A same-cycle op is older than the branch, so its mask stalls the request too.
    always_comb begin
        cond_need  = cond_flag_need(cond_code);
        cond_ready = !(((state_q == ST_WAIT) && ((cond_need & mask_q) != 4'b0000)) ||
                       (op_accept && ((cond_need & op_mask) != 4'b0000)));
        eval_flags = (flag_d & flag_we) | (flags_q & ~flag_we);
    end

    flag_cond_eval u_cond_eval (
        .flags     (eval_flags),
        .cond_code (cond_code),
        .taken     (eval_taken)
    );

    always_comb begin
        cond_accept  = cond_valid && cond_ready;
        cond_done_d  = cond_accept;
        cond_taken_d = cond_accept && eval_taken;
    end

    assign cond_done  = cond_done_q;
    assign cond_taken = cond_taken_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            mask_q       <= 4'b0000;
            samp_q       <= 4'b0000;
            cond_done_q  <= 1'b0;
            cond_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            samp_q       <= samp_d;
            cond_done_q  <= cond_done_d;
            cond_taken_q <= cond_taken_d;
        end
    end

endmodule

// File: tb/tb_flag_update_sequencer.sv
// Randomized scoreboard bench for flag_update_sequencer with a timestamp-based reference model.
module tb_flag_update_sequencer;

    localparam int LAT    = 3;
    localparam int CYCLES = 3000;
    localparam int QUIET  = 20;

    logic       clock;
    logic       reset;
    logic       op_valid;
    logic [4:0] op_code;
    logic       op_ready;
    logic       alu_z, alu_c, alu_s, alu_o;
    logic [3:0] flags_q;
    logic [3:0] flag_we;
    logic [3:0] flag_d;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       cond_ready;
    logic       cond_done;
    logic       cond_taken;
    logic       busy;

    flag_update_sequencer #(.ALU_LAT(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_s      (alu_s),
        .alu_o      (alu_o),
        .flags_q    (flags_q),
        .flag_we    (flag_we),
        .flag_d     (flag_d),
        .cond_valid (cond_valid),
        .cond_code  (cond_code),
        .cond_ready (cond_ready),
        .cond_done  (cond_done),
        .cond_taken (cond_taken),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int cyc; logic [3:0] we; logic [3:0] d; } strobe_t;
    typedef struct { int cyc; logic taken; } cres_t;

    strobe_t sq[$];
    cres_t   cq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    bit mon_en = 0;

    bit         have_pend = 0;
    int         p_t       = 0;
    logic [3:0] p_mask    = 4'b0;
    logic [3:0] p_samp    = 4'b0;
    bit         cond_hold = 0;
    logic       exp_op_ready, exp_cond_ready, exp_busy;

    function automatic logic [3:0] ref_mask(input logic [4:0] code);
        int v = int'(code);
        if (v == 8 || v == 9) return 4'b0111;
        if (v <= 6 && v != 2) return 4'b1111;
        if (v == 17 || v == 18 || (v >= 20 && v <= 30)) return 4'b0101;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] ref_need(input logic [3:0] code);
        int v = int'(code);
        if (v == 0 || v == 15) return 4'b0000;
        if (v <= 2)  return 4'b0001;
        if (v <= 4)  return 4'b0010;
        if (v <= 6)  return 4'b0100;
        if (v <= 8)  return 4'b1000;
        if (v <= 10) return 4'b1100;
        if (v <= 12) return 4'b1101;
        return 4'b0011;
    endfunction

    function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] code);
        bit z = f[0], c = f[1], s = f[2], o = f[3];
        bit lt = (s != o);
        bit res;
        case (int'(code))
            0: res = 1;   1: res = z;       2: res = !z;
            3: res = c;   4: res = !c;      5: res = s;
            6: res = !s;  7: res = o;       8: res = !o;
            9: res = lt;  10: res = !lt;    11: res = z || lt;
            12: res = !z && !lt;            13: res = c || z;
            14: res = !c && !z;             default: res = 0;
        endcase
        return res;
    endfunction

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cycle, act, exp);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model by one cycle.
    task automatic apply_stimulus(input bit quiet);
        bit         in_wait, in_commit, rst_now, acc;
        logic [3:0] nmask, need, eflags, alu_v;
        if (have_pend && cycle > p_t + LAT + 1) have_pend = 0;
        in_wait      = have_pend && cycle <= p_t + LAT;
        in_commit    = have_pend && cycle == p_t + LAT + 1;
        exp_op_ready = !in_wait;
        exp_busy     = in_wait || in_commit;

        rst_now = !quiet && !in_commit && ($urandom_range(0, 99) < 2);
        reset   = !rst_now;
        alu_v   = 4'($urandom);
        {alu_o, alu_s, alu_c, alu_z} = alu_v;
        flags_q = 4'($urandom);

        if (in_wait && cycle == p_t + LAT) begin
            p_samp = alu_v & p_mask;
            sq.push_back('{cycle + 1, p_mask, p_samp});
        end

        op_valid = !rst_now && !quiet && ($urandom_range(0, 99) < 60);
        op_code  = 5'($urandom);
        acc      = op_valid && exp_op_ready;
        nmask    = acc ? ref_mask(op_code) : 4'b0000;

        if (!cond_hold && !rst_now && !quiet && ($urandom_range(0, 99) < 50)) begin
            cond_hold = 1;
            cond_code = 4'($urandom);
        end
        cond_valid     = cond_hold && !rst_now;
        need           = ref_need(cond_code);
        exp_cond_ready = !((in_wait && ((need & p_mask) != 4'b0)) || ((nmask & need) != 4'b0));
        if (cond_valid && exp_cond_ready) begin
            eflags = in_commit ? (p_samp | (flags_q & ~p_mask)) : flags_q;
            cq.push_back('{cycle + 1, ref_taken(eflags, cond_code)});
            cond_hold = 0;
        end

        if (nmask != 4'b0) begin
            have_pend = 1;
            p_t       = cycle;
            p_mask    = nmask;
        end
        if (rst_now) begin
            have_pend = 0;
            cond_hold = 0;
            while (sq.size() > 0 && sq[$].cyc > cycle) void'(sq.pop_back());
        end
    endtask

    initial begin
        strobe_t s;
        cres_t   r;
        wait (mon_en);
        forever begin
            @(negedge clock);
            if (flag_we != 4'b0) begin
                if (sq.size() == 0 || sq[0].cyc != cycle) begin
                    check_output("flag_we_unexpected", flag_we, 4'b0);
                end else begin
                    s = sq.pop_front();
                    check_output("flag_we", flag_we, s.we);
                    check_output("flag_d", flag_d, s.d);
                end
            end else if (sq.size() > 0 && sq[0].cyc <= cycle) begin
                s = sq.pop_front();
                check_output("flag_we_missing", flag_we, s.we);
            end
            if (cond_done) begin
                if (cq.size() == 0 || cq[0].cyc != cycle) begin
                    check_output("cond_done_unexpected", 4'(cond_done), 4'd0);
                end else begin
                    r = cq.pop_front();
                    check_output("cond_taken", 4'(cond_taken), 4'(r.taken));
                end
            end else if (cq.size() > 0 && cq[0].cyc <= cycle) begin
                r = cq.pop_front();
                check_output("cond_done_missing", 4'(cond_done), 4'd1);
            end
        end
    end

    initial begin
        reset      = 1'b0;
        op_valid   = 1'b0;
        op_code    = 5'd0;
        {alu_o, alu_s, alu_c, alu_z} = 4'b0;
        flags_q    = 4'b0;
        cond_valid = 1'b0;
        cond_code  = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_flag_we", flag_we, 4'b0);
        check_output("reset_flag_d", flag_d, 4'b0);
        check_output("reset_cond_done", 4'(cond_done), 4'd0);
        check_output("reset_cond_taken", 4'(cond_taken), 4'd0);
        check_output("reset_busy", 4'(busy), 4'd0);
        check_output("reset_op_ready", 4'(op_ready), 4'd1);
        reset  = 1'b1;
        mon_en = 1;

        for (int i = 0; i < CYCLES; i++) begin
            @(posedge clock);
            #1;
            cycle++;
            apply_stimulus(i >= CYCLES - QUIET);
            @(negedge clock);
            check_output("op_ready", 4'(op_ready), 4'(exp_op_ready));
            check_output("cond_ready", 4'(cond_ready), 4'(exp_cond_ready));
            check_output("busy", 4'(busy), 4'(exp_busy));
        end

        #1;
        n_cmp++;
        if (sq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: strobes left %0d, results left %0d, expected 0 and 0",
                     sq.size(), cq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
